// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Registered N-bit ALU with NZCV flags, XOR, four shift types and an
//            optional iterative shift-add multiplier behind busy/done.
//            Define ALU_SEQ_MUL_EN to build the multiplier (MUL_RUN state).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic [2:0]    ALU_control,
    input  logic [SW-1:0] cantidad_shifts,
    input  logic [1:0]    tipo_shift,
    output logic [N-1:0]  Resultado,
    output logic [3:0]    ALU_flags,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] c_OP_ADD   = 3'b000;
    localparam logic [2:0] c_OP_SUB   = 3'b001;
    localparam logic [2:0] c_OP_AND   = 3'b010;
    localparam logic [2:0] c_OP_OR    = 3'b011;
    localparam logic [2:0] c_OP_SHIFT = 3'b100;
    localparam logic [2:0] c_OP_XOR   = 3'b101;
    localparam logic [2:0] c_OP_MUL   = 3'b110;
    localparam logic [2:0] c_OP_RSV   = 3'b111;

    localparam logic [1:0] c_SH_LSL = 2'b00;
    localparam logic [1:0] c_SH_LSR = 2'b01;
    localparam logic [1:0] c_SH_ASR = 2'b10;

    logic [N-1:0]   w_b_op;
    logic           w_cin;
    logic [N:0]     w_sum;
    logic [N:0]     w_lsl_wide;
    logic [N:0]     w_lsr_wide;
    logic [N:0]     w_asr_wide;
    logic [2*N-1:0] w_ror_wide;
    logic [N-1:0]   w_res;
    logic           w_c;
    logic           w_v;
    logic [3:0]     w_flags;

    logic [N-1:0]   r_result;
    logic [3:0]     r_flags;
    logic           r_done;

    // Subtraction reuses the adder as a + ~b + 1 so C reads as "no borrow".
    assign w_b_op = (ALU_control == c_OP_SUB) ? ~b : b;
    assign w_cin  = (ALU_control == c_OP_SUB);
    assign w_sum  = {1'b0, a} + {1'b0, w_b_op} + {{N{1'b0}}, w_cin};

    // One guard bit on each side of the shifter captures the last bit shifted out.
    assign w_lsl_wide = {1'b0, a} << cantidad_shifts;
    assign w_lsr_wide = {a, 1'b0} >> cantidad_shifts;
    assign w_asr_wide = $unsigned($signed({a, 1'b0}) >>> cantidad_shifts);
    assign w_ror_wide = {a, a} >> cantidad_shifts;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (ALU_control)
            c_OP_ADD: begin
                w_res = w_sum[N-1:0];
                w_c   = w_sum[N];
                w_v   = (a[N-1] == b[N-1]) & (w_sum[N-1] != a[N-1]);
            end
            c_OP_SUB: begin
                w_res = w_sum[N-1:0];
                w_c   = w_sum[N];
                w_v   = (a[N-1] != b[N-1]) & (w_sum[N-1] != a[N-1]);
            end
            c_OP_AND: w_res = a & b;
            c_OP_OR:  w_res = a | b;
            c_OP_XOR: w_res = a ^ b;
            c_OP_SHIFT: begin
                case (tipo_shift)
                    c_SH_LSL: begin
                        w_res = w_lsl_wide[N-1:0];
                        w_c   = w_lsl_wide[N];
                    end
                    c_SH_LSR: begin
                        w_res = w_lsr_wide[N:1];
                        w_c   = w_lsr_wide[0];
                    end
                    c_SH_ASR: begin
                        w_res = w_asr_wide[N:1];
                        w_c   = w_asr_wide[0];
                    end
                    default: begin
                        w_res = w_ror_wide[N-1:0];
                        w_c   = w_ror_wide[N-1];
                    end
                endcase
                if (cantidad_shifts == '0) begin
                    w_c = 1'b0;
                end
            end
            c_OP_MUL, c_OP_RSV: begin
                w_res = '0;
            end
            default: begin
                w_res = '0;
            end
        endcase
    end

    assign w_flags = {w_res[N-1], (w_res == '0), w_c, w_v};

`ifdef ALU_SEQ_MUL_EN
    localparam logic [0:0]    c_S_IDLE    = 1'b0;
    localparam logic [0:0]    c_S_MUL_RUN = 1'b1;
    localparam logic [SW-1:0] c_CNT_LAST  = SW'(N - 1);
    localparam logic [SW-1:0] c_CNT_ONE   = SW'(1);

    logic [0:0]    r_state;
    logic [SW-1:0] r_cnt;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_mcand;
    logic [N-1:0]  r_mplier;
    logic [N-1:0]  w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_result <= '0;
            r_flags  <= 4'b0000;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == c_S_IDLE) begin
                if (start) begin
                    if (ALU_control == c_OP_MUL) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= c_S_MUL_RUN;
                    end else begin
                        r_result <= w_res;
                        r_flags  <= w_flags;
                        r_done   <= 1'b1;
                    end
                end
            end else begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + c_CNT_ONE;
                // The final partial product is folded in on the completing edge.
                if (r_cnt == c_CNT_LAST) begin
                    r_result <= w_acc_next;
                    r_flags  <= {w_acc_next[N-1], (w_acc_next == '0), 2'b00};
                    r_done   <= 1'b1;
                    r_state  <= c_S_IDLE;
                end
            end
        end
    end

    assign busy = (r_state == c_S_MUL_RUN);
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_flags  <= 4'b0000;
            r_done   <= 1'b0;
        end else begin
            r_done <= start;
            if (start) begin
                r_result <= w_res;
                r_flags  <= w_flags;
            end
        end
    end

    assign busy = 1'b0;
`endif

    assign Resultado = r_result;
    assign ALU_flags = r_flags;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// Self-checking bench for alu_seq: scoreboard queue filled at issue time,
// drained by a monitor on every done pulse.
module tb_alu_seq;
    localparam int N  = 32;
    localparam int SW = $clog2(N);
`ifdef ALU_SEQ_MUL_EN
    localparam int MUL_EXTRA = N;
    localparam int MUL_BUSY  = N;
`else
    localparam int MUL_EXTRA = 0;
    localparam int MUL_BUSY  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic [2:0]    ALU_control = 3'b000;
    logic [SW-1:0] cantidad_shifts = '0;
    logic [1:0]    tipo_shift = 2'b00;
    logic [N-1:0]  Resultado;
    logic [3:0]    ALU_flags;
    logic          busy;
    logic          done;

    alu_seq #(.N(N), .SW(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ALU_control(ALU_control), .cantidad_shifts(cantidad_shifts),
        .tipo_shift(tipo_shift), .Resultado(Resultado), .ALU_flags(ALU_flags),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] res;
        logic [3:0]   flags;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: plain arithmetic on wide integers.
    function automatic logic [N+3:0] model(input logic [2:0] op, input logic [N-1:0] x,
                                           input logic [N-1:0] y, input int sh,
                                           input logic [1:0] ts);
        logic [N-1:0] r;
        logic c, v;
        longint ux, uy, sx, sy, s, lim;
        r = '0; c = 1'b0; v = 1'b0;
        ux = longint'(x); uy = longint'(y);
        sx = longint'($signed(x)); sy = longint'($signed(y));
        lim = longint'(1) << (N - 1);
        case (op)
            3'd0: begin
                r = x + y;
                c = (ux + uy) >= (longint'(1) << N);
                s = sx + sy;
                v = (s >= lim) || (s < -lim);
            end
            3'd1: begin
                r = x - y;
                c = (ux >= uy);
                s = sx - sy;
                v = (s >= lim) || (s < -lim);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd5: r = x ^ y;
            3'd4: begin
                case (ts)
                    2'd0: begin
                        r = x << sh;
                        if (sh != 0) c = ((ux >> (N - sh)) & 64'd1) != 0;
                    end
                    2'd1: begin
                        r = x >> sh;
                        if (sh != 0) c = ((ux >> (sh - 1)) & 64'd1) != 0;
                    end
                    2'd2: begin
                        r = $signed(x) >>> sh;
                        if (sh != 0) c = ((ux >> (sh - 1)) & 64'd1) != 0;
                    end
                    default: begin
                        r = (sh == 0) ? x : ((x >> sh) | (x << (N - sh)));
                        if (sh != 0) c = r[N-1];
                    end
                endcase
            end
`ifdef ALU_SEQ_MUL_EN
            3'd6: r = x * y;
`endif
            default: r = '0;
        endcase
        return {r, r[N-1], (r == '0), c, v};
    endfunction

    task automatic issue(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y,
                         input int sh, input logic [1:0] ts);
        exp_t e;
        logic [N+3:0] m;
        m = model(op, x, y, sh, ts);
        e.res   = m[N+3:4];
        e.flags = m[3:0];
        e.cyc   = cyc + 1 + ((op == 3'b110) ? MUL_EXTRA : 0);
        q.push_back(e);
        start = 1'b1; ALU_control = op; a = x; b = y;
        cantidad_shifts = SW'(sh); tipo_shift = ts;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Multiply and count busy cycles; optionally poke an ADD mid-run that must be ignored.
    task automatic run_mul(input logic [N-1:0] x, input logic [N-1:0] y, input int inject_at);
        int n;
        issue(3'b110, x, y, 0, 2'b00);
        n = 0;
        while (busy && n < N + 8) begin
            n++;
            if (n == inject_at) begin
                start = 1'b1; ALU_control = 3'b000; a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("mul_busy_cycles", 64'(n), 64'(MUL_BUSY));
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", 64'(Resultado), 64'(e.res));
                chk("flags", 64'(ALU_flags), 64'(e.flags));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t dropped;
        int op, n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", 64'(Resultado), 64'd0);
        chk("reset_flags", 64'(ALU_flags), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        idle(1);

        issue(3'd0, 32'h7FFF_FFFF, 32'h1, 0, 2'b00);
        idle(2);
        issue(3'd1, 32'd5, 32'd5, 0, 2'b00);
        issue(3'd1, 32'd3, 32'd5, 0, 2'b00);
        issue(3'd4, 32'h8000_0001, '0, 1, 2'b00);
        issue(3'd4, 32'h8000_0001, '0, 1, 2'b01);
        issue(3'd4, 32'h8000_0001, '0, 1, 2'b10);
        issue(3'd4, 32'h8000_0001, '0, 1, 2'b11);
        issue(3'd4, 32'h8000_0001, '0, 0, 2'b00);
        issue(3'd4, 32'h8000_0001, '0, 31, 2'b11);
        issue(3'd5, 32'hF0F0_1234, 32'h0FF0_1234, 0, 2'b00);
        issue(3'd7, 32'h1234, 32'h5678, 0, 2'b00);
        idle(1);

        run_mul(32'h0001_0003, 32'h0000_0005, 5);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        // Back-to-back start right on the multiply's done cycle.
        issue(3'd3, 32'hF0, 32'h0F, 0, 2'b00);
        idle(1);

`ifdef ALU_SEQ_MUL_EN
        issue(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 0, 2'b00);
        idle(8);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dropped = q.pop_back();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_result", 64'(Resultado), 64'd0);
        chk("abort_flags", 64'(ALU_flags), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        issue(3'd3, 32'hF0, 32'h0F, 0, 2'b00);
        idle(N + 4);
`else
        issue(3'd6, 32'h0001_0003, 32'h5, 0, 2'b00);
        idle(1);
`endif

        issue(3'd0, 32'd10, 32'd20, 0, 2'b00);
        issue(3'd1, 32'd1, 32'd2, 0, 2'b00);
        issue(3'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, 2'b00);
        issue(3'd3, 32'h0, 32'h0, 0, 2'b00);
        idle(1);

        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 7);
            if (op == 6) begin
                run_mul($urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 300)) : 32'($urandom), 0);
            end else begin
                issue(3'(op), $urandom, $urandom, $urandom_range(0, N - 1), 2'($urandom_range(0, 3)));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end

        n = 0;
        while (q.size() != 0 && n < 3 * N) begin
            idle(1);
            n++;
        end
        idle(2);
        chk("pending_results", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the team's 32-bit combinational ALU, placed in the execute stage of the processor datapath. It accepts one operation per `start` pulse and registers the result and NZCV flags. Single-cycle operations complete in one clock. The block adds XOR, four shift types with carry-out, and an optional iterative shift-add multiplier that runs over N cycles behind a `busy`/`done` handshake.

## Interface
- `N`, 32: operand/result width; must be ≥ 4 and a power of two.
- `SW`, $clog2(N): width of the shift-amount port.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  operation request; sampled only when `busy`=0
- `a`, `b`  in  N  operands
- `ALU_control`  in  3  opcode
- `cantidad_shifts`  in  SW  shift amount
- `tipo_shift`  in  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR
- `Resultado`  out  N  registered result
- `ALU_flags`  out  4  registered flags: [3] N, [2] Z, [1] C, [0] V
- `busy`  out  1  multiply in progress
- `done`  out  1  one-cycle pulse when `Resultado`/`ALU_flags` are updated

## Operation
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a+~b+1.
  - 010 AND.
  - 011 OR.
  - 100 SHIFT: `a` shifted by `cantidad_shifts` per `tipo_shift`; `b` is ignored.
  - 101 XOR.
  - 110 MUL: low N bits of a×b, unsigned.
  - 111 reserved: result 0.
- Flags (all opcodes):
  - N = `Resultado`[N-1].
  - Z = (`Resultado`==0).
- C flag:
  - ADD/SUB: adder carry-out. For SUB, C=1 means no borrow (a ≥ b unsigned).
  - SHIFT with shamt≠0: last bit shifted out. LSL: a[N-shamt]; LSR/ASR: a[shamt-1]; ROR: `Resultado`[N-1].
  - All other cases: 0.
- V flag:
  - ADD: (a[N-1]==b[N-1]) & (R[N-1]≠a[N-1]).
  - SUB: (a[N-1]≠b[N-1]) & (R[N-1]≠a[N-1]).
  - All other opcodes: 0.
- State machine:
  - IDLE: `start`=1 with a non-MUL opcode registers the result and flags and asserts `done` for the next cycle; the machine stays in IDLE.
  - IDLE: `start`=1 with MUL latches a, b and clears the accumulator, then goes to MUL_RUN with the counter at 0.
  - MUL_RUN: each cycle, if multiplier bit 0 =1, add the multiplicand to the accumulator. Then shift the multiplicand left, shift the multiplier right, and increment the counter.
  - MUL_RUN: on the edge where the counter reaches N-1, register the accumulator and flags, pulse `done`, and return to IDLE.
- `busy`=1 exactly while in MUL_RUN.
- `start` while `busy`=1 is ignored; the request is not queued.
- Operands and opcode are sampled only on the accepting edge. Input changes during MUL_RUN have no effect.
- `Resultado`/`ALU_flags` hold their last value between completions.
- Reset (any state, including mid-MUL):
  - `Resultado`=0, `ALU_flags`=4'b0000, `busy`=0, `done`=0, state IDLE, counter and accumulator 0.
  - An aborted multiply produces no `done`.
- `rst` and `start` asserted on the same edge: reset wins.

## Timing
- Non-MUL latency is 1: `start` sampled at edge E0 → outputs valid and `done`=1 in the cycle after E0.
- Back-to-back non-MUL `start` every cycle is legal: one result per clock, and `done` stays high continuously.
- MUL latency is N cycles: accepted at E0, `busy`=1 from after E0 through edge EN-1's cycle, `done`=1 in the cycle after EN.
- A new `start` is accepted in the same cycle that `done` is high for a multiply.
- `done` is never high for two cycles from a single request.

## Configuration
- `ALU_SEQ_MUL_EN` defined: multiplier and the MUL_RUN state are compiled in, as described above.
- `ALU_SEQ_MUL_EN` undefined:
  - Opcode 110 behaves like 111: result 0, flags 4'b0100, 1-cycle latency.
  - `busy` is tied to 0 and no multiplier logic is synthesised.

## Test plan
- Reset and overflow ADD:
  - Hold `rst` 2 cycles → all outputs 0.
  - ADD a=32'h7FFF_FFFF, b=1 → `Resultado`=32'h8000_0000, flags=1001, `done` for 1 cycle.
- SUB equal and borrow:
  - SUB a=5, b=5 → 0, flags=0110.
  - SUB a=3, b=5 → 32'hFFFF_FFFE, flags=1000.
- Shifts:
  - a=32'h8000_0001, shamt=1: LSL → 32'h0000_0002, C=1; ASR → 32'hC000_0000, flags=1010; ROR → 32'hC000_0000, C=1.
  - shamt=0 → C=0.
- MUL:
  - a=32'h0001_0003, b=32'h0000_0005 → `busy` high 32 cycles, then `Resultado`=32'h0005_000F, flags=0000.
  - `start`+ADD issued mid-run → ignored.
- Reset mid-MUL:
  - Assert `rst` at cycle 10 of a multiply → `busy`=0 and outputs 0 next cycle, no `done`.
  - Immediately issue OR a=32'hF0, b=32'h0F → 32'hFF.
- Back-to-back:
  - Four consecutive non-MUL starts → `done` high 4 consecutive cycles with results in order.
  - Built without `ALU_SEQ_MUL_EN`: MUL → 0, flags=0100, 1 cycle.
